// File: rtl/prog_clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// The divider runs a period counter 0..N-1 and derives its output level
// from the counter and the active configuration.
package prog_clk_div_pkg;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
    logic             duty50;
  } clk_div_cfg_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A configuration is usable only if it yields at least one low and one
  // high cycle; in 50% mode the high time is derived, so only N matters.
  function automatic logic cfg_legal(clk_div_cfg_t cfg);
    logic ok;
    ok = (cfg.div >= CNT_W'(2));
    if (!cfg.duty50) begin
      ok = ok && (cfg.high != '0) && (cfg.high < cfg.div);
    end
    return ok;
  endfunction

  // Posedge-domain output level for a given counter value.  For odd N in
  // 50% mode the high phase is one cycle longer here; the negedge flop
  // trims half a cycle off its front.
  function automatic logic pos_level(clk_div_cfg_t cfg, logic [CNT_W-1:0] cnt);
    logic lvl;
    if (!cfg.duty50) begin
      lvl = (cnt < cfg.high);
    end else if (cfg.div[0]) begin
      lvl = (cnt <= (cfg.div >> 1));
    end else begin
      lvl = (cnt < (cfg.div >> 1));
    end
    return lvl;
  endfunction

  // True when the output needs the half-cycle extension flop.
  function automatic logic odd_half(clk_div_cfg_t cfg);
    return cfg.duty50 & cfg.div[0];
  endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Control/status bundle of the programmable clock divider.
// The master side supplies run enable and configuration loads; the slave
// side (the divider) returns the divided clock and status strobes.
interface prog_clk_div_if;

  logic                                i_en;
  logic                                i_load;
  logic [prog_clk_div_pkg::CNT_W-1:0]  i_div;
  logic [prog_clk_div_pkg::CNT_W-1:0]  i_high;
  logic                                i_duty50;
  logic                                o_clk;
  logic                                o_period_start;
  logic                                o_cfg_err;
  logic                                o_pending;

  modport master (
    output i_en, i_load, i_div, i_high, i_duty50,
    input  o_clk, o_period_start, o_cfg_err, o_pending
  );

  modport slave (
    input  i_en, i_load, i_div, i_high, i_duty50,
    output o_clk, o_period_start, o_cfg_err, o_pending
  );

endinterface

// File: rtl/prog_clk_div_half_ext.sv
// Half-cycle trimmer for odd-ratio 50% duty.  A negedge copy of the
// posedge level is ANDed with it, delaying the rising edge by half an
// input clock so the high time becomes exactly N/2 input periods.
module prog_clk_div_half_ext (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pos,
  input  logic i_odd,
  output logic o_clk
);

  logic neg_q;

  // Negedge copy of the posedge level; held low outside odd 50% mode.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= i_odd & i_pos;
    end
  end

  assign o_clk = i_odd ? (i_pos & neg_q) : i_pos;

endmodule

// File: rtl/prog_clk_div.sv
// Runtime-programmable integer clock divider.
// New configurations are staged in a shadow register and only become
// active when a period finishes (or immediately while idle), so the
// output never produces a shortened high or low phase.
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned DIV_RST  = 7,
  parameter int unsigned HIGH_RST = 4,
  parameter int unsigned D50_RST  = 0
) (
  input logic           i_clk,
  input logic           i_rst,
  prog_clk_div_if.slave bus
);

  localparam clk_div_cfg_t RST_CFG = '{
    div:    CNT_W'(DIV_RST),
    high:   CNT_W'(HIGH_RST),
    duty50: 1'(D50_RST)
  };

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  clk_div_cfg_t     cfg_q,     cfg_d;
  clk_div_cfg_t     shd_q,     shd_d;
  logic             pending_q, pending_d;
  logic             pos_q,     pos_d;
  logic             pstart_q,  pstart_d;
  logic             err_q,     err_d;

  clk_div_cfg_t     load_cfg;
  logic             load_ok;
  logic             at_end;
  logic             apply;
  logic             clk_out;

  // State register; reset also drops the output immediately mid-period.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cfg_q     <= RST_CFG;
      shd_q     <= RST_CFG;
      pending_q <= 1'b0;
      pos_q     <= 1'b0;
      pstart_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cfg_q     <= cfg_d;
      shd_q     <= shd_d;
      pending_q <= pending_d;
      pos_q     <= pos_d;
      pstart_q  <= pstart_d;
      err_q     <= err_d;
    end
  end

  // Next-state: period counting, boundary-only config apply, load checking.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cfg_d     = cfg_q;
    shd_d     = shd_q;
    pending_d = pending_q;
    pstart_d  = 1'b0;
    err_d     = 1'b0;
    apply     = 1'b0;

    load_cfg = '{div: bus.i_div, high: bus.i_high, duty50: bus.i_duty50};
    load_ok  = cfg_legal(load_cfg);
    at_end   = (cnt_q == (cfg_q.div - CNT_W'(1)));

    case (state_q)
      IDLE: begin
        apply = pending_q;
        cnt_d = '0;
        if (bus.i_en) begin
          state_d  = RUN;
          pstart_d = 1'b1;
        end
      end
      RUN: begin
        if (at_end) begin
          apply = pending_q;
          cnt_d = '0;
          if (bus.i_en) begin
            pstart_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (apply) begin
      cfg_d     = shd_q;
      pending_d = 1'b0;
    end

    // A load landing on the apply edge refills the shadow after the old
    // shadow has been consumed, so it stays pending for the next boundary.
    if (bus.i_load) begin
      if (load_ok) begin
        shd_d     = load_cfg;
        pending_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    pos_d = (state_d == RUN) ? pos_level(cfg_d, cnt_d) : 1'b0;
  end

  prog_clk_div_half_ext u_half_ext (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_pos (pos_q),
    .i_odd (odd_half(cfg_q)),
    .o_clk (clk_out)
  );

  assign bus.o_clk          = clk_out;
  assign bus.o_period_start = pstart_q;
  assign bus.o_cfg_err      = err_q;
  assign bus.o_pending      = pending_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for the programmable clock divider: cycle-by-cycle
// sequences around enable, loads and reset, plus a table of configuration
// loads whose resulting waveform is measured in tenths of an input cycle.
module tb_prog_clk_div;
  import prog_clk_div_pkg::*;

  localparam int HALF  = 50;
  localparam int STEP  = 10;
  localparam int LIMIT = 1000;

  logic clk;
  logic rst;

  prog_clk_div_if bus ();

  prog_clk_div dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #HALF clk = ~clk;
  end

  typedef struct {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
    logic             duty50;
    logic             expErr;
    int               expPeriod;
    int               expHigh;
  } vec_t;

  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [CNT_W-1:0] div, input logic [CNT_W-1:0] high,
                               input logic duty50);
    @(negedge clk);
    bus.i_load   = 1'b1;
    bus.i_div    = div;
    bus.i_high   = high;
    bus.i_duty50 = duty50;
    @(negedge clk);
    bus.i_load   = 1'b0;
  endtask

  task automatic waitApplied(input string name);
    int n;
    n = 0;
    while (bus.o_pending === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, bus.o_pending, 0);
  endtask

  task automatic measureWave(output int period, output int highT, output logic ok);
    int steps;
    int t0;
    int t1;
    int t2;
    steps = 0;
    @(negedge clk);
    #5;
    while (bus.o_clk !== 1'b0 && steps < LIMIT) begin #STEP; steps++; end
    while (bus.o_clk !== 1'b1 && steps < LIMIT) begin #STEP; steps++; end
    t0 = steps;
    while (bus.o_clk !== 1'b0 && steps < LIMIT) begin #STEP; steps++; end
    t1 = steps;
    while (bus.o_clk !== 1'b1 && steps < LIMIT) begin #STEP; steps++; end
    t2 = steps;
    ok     = (steps < LIMIT);
    period = t2 - t0;
    highT  = t1 - t0;
  endtask

  initial begin
    logic [0:25] expClk;
    logic [0:25] expPs;
    logic [0:25] expPend;
    logic [0:7]  dropClk;
    int          per;
    int          hi;
    logic        ok;
    int          n;

    rst          = 1'b1;
    bus.i_en     = 1'b0;
    bus.i_load   = 1'b0;
    bus.i_div    = '0;
    bus.i_high   = '0;
    bus.i_duty50 = 1'b0;

    vecs[0] = '{div: 8'd6, high: 8'd1, duty50: 1'b0, expErr: 1'b0, expPeriod: 60, expHigh: 10};
    vecs[1] = '{div: 8'd5, high: 8'd0, duty50: 1'b1, expErr: 1'b0, expPeriod: 50, expHigh: 25};
    vecs[2] = '{div: 8'd4, high: 8'd4, duty50: 1'b0, expErr: 1'b1, expPeriod: 50, expHigh: 25};
    vecs[3] = '{div: 8'd1, high: 8'd0, duty50: 1'b0, expErr: 1'b1, expPeriod: 50, expHigh: 25};
    vecs[4] = '{div: 8'd8, high: 8'd0, duty50: 1'b1, expErr: 1'b0, expPeriod: 80, expHigh: 40};
    vecs[5] = '{div: 8'd3, high: 8'd2, duty50: 1'b0, expErr: 1'b0, expPeriod: 30, expHigh: 20};
    vecs[6] = '{div: 8'd9, high: 8'd0, duty50: 1'b1, expErr: 1'b0, expPeriod: 90, expHigh: 45};
    vecs[7] = '{div: 8'd7, high: 8'd0, duty50: 1'b0, expErr: 1'b1, expPeriod: 90, expHigh: 45};
    vecs[8] = '{div: 8'd2, high: 8'd1, duty50: 1'b0, expErr: 1'b0, expPeriod: 20, expHigh: 10};
    vecs[9] = '{div: 8'd10, high: 8'd9, duty50: 1'b0, expErr: 1'b0, expPeriod: 100, expHigh: 90};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstClk",     bus.o_clk,          0);
    checkOutput("rstPstart",  bus.o_period_start, 0);
    checkOutput("rstCfgErr",  bus.o_cfg_err,      0);
    checkOutput("rstPending", bus.o_pending,      0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idleClk",    bus.o_clk,          0);
    checkOutput("idlePstart", bus.o_period_start, 0);

    // Default 7/4 for two periods, then a mid-period load of 6/1 at cnt=2
    expClk  = 26'b1111000_1111000_100000_100000;
    expPs   = 26'b1000000_1000000_100000_100000;
    expPend = 26'b0000000_0001111_000000_000000;
    bus.i_en = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      checkOutput($sformatf("seqClk[%0d]", k),  bus.o_clk,          int'(expClk[k]));
      checkOutput($sformatf("seqPs[%0d]", k),   bus.o_period_start, int'(expPs[k]));
      checkOutput($sformatf("seqPend[%0d]", k), bus.o_pending,      int'(expPend[k]));
      checkOutput($sformatf("seqErr[%0d]", k),  bus.o_cfg_err,      0);
      if (k == 9) begin
        bus.i_load   = 1'b1;
        bus.i_div    = 8'd6;
        bus.i_high   = 8'd1;
        bus.i_duty50 = 1'b0;
      end else if (k == 10) begin
        bus.i_load = 1'b0;
      end
    end

    // Table of loads: legality response, then the resulting waveform
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].div, vecs[i].high, vecs[i].duty50);
      checkOutput($sformatf("vecErr[%0d]", i),     bus.o_cfg_err, int'(vecs[i].expErr));
      checkOutput($sformatf("vecPending[%0d]", i), bus.o_pending, int'(!vecs[i].expErr));
      @(negedge clk);
      checkOutput($sformatf("vecErrPulse[%0d]", i), bus.o_cfg_err, 0);
      if (!vecs[i].expErr) begin
        waitApplied($sformatf("vecApplied[%0d]", i));
      end
      measureWave(per, hi, ok);
      checkOutput($sformatf("vecMeasured[%0d]", i), int'(ok), 1);
      checkOutput($sformatf("vecPeriod[%0d]", i), per, vecs[i].expPeriod);
      checkOutput($sformatf("vecHigh[%0d]", i),   hi,  vecs[i].expHigh);
    end

    // Enable dropped at cnt=2 of N=7: period finishes, then idle low
    applyStimulus(8'd7, 8'd4, 1'b0);
    waitApplied("dropApplied");
    n = 0;
    while (bus.o_period_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("dropFoundStart", bus.o_period_start, 1);
    @(negedge clk);
    @(negedge clk);
    bus.i_en = 1'b0;
    dropClk = 8'b1000_0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("dropClk[%0d]", k), bus.o_clk,          int'(dropClk[k]));
      checkOutput($sformatf("dropPs[%0d]", k),  bus.o_period_start, 0);
    end
    bus.i_en = 1'b1;
    @(negedge clk);
    checkOutput("reenClk",  bus.o_clk,          1);
    checkOutput("reenPs",   bus.o_period_start, 1);
    @(negedge clk);
    checkOutput("reenClk2", bus.o_clk,          1);
    checkOutput("reenPs2",  bus.o_period_start, 0);

    // Reset while odd 50% output is high
    applyStimulus(8'd5, 8'd0, 1'b1);
    waitApplied("rstOddApplied");
    #5;
    n = 0;
    while (bus.o_clk !== 1'b1 && n < 100) begin
      #STEP;
      n++;
    end
    checkOutput("rstOddHigh", bus.o_clk, 1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rstAsyncClk",    bus.o_clk,          0);
    checkOutput("rstAsyncPstart", bus.o_period_start, 0);
    checkOutput("rstAsyncPend",   bus.o_pending,      0);
    repeat (2) @(negedge clk);
    checkOutput("rstHoldClk", bus.o_clk, 0);
    rst = 1'b0;
    measureWave(per, hi, ok);
    checkOutput("rstCfgMeasured", int'(ok), 1);
    checkOutput("rstCfgPeriod",   per, 70);
    checkOutput("rstCfgHigh",     hi,  40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
